csr_unit: RTL

- Parametrised control/status register block for the 3-stage RV32 pipeline.
- Replaces the single hard-wired tohost register in the datapath with a mapped set: tohost, a bank of scratch registers, and cycle and instret counters.
- Supports CSRRW, CSRRS and CSRRC, including the immediate variants; the datapath muxes the source operand before it reaches this block.
- Read port sits in stage 1 (S1); write/commit port sits in stage 3 (S3).

---
 rtl/csr_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// CSR block for the 3-stage RV32 pipeline: tohost, scratch bank, cycle/instret counters.
// Reads are combinational in S1; read-modify-write commits happen on the clock edge in S3.
module csr_unit #(
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned COUNTER_BITS = 64,
    parameter int unsigned NUM_SCRATCH  = 4,
    parameter logic [11:0] SCRATCH_BASE = 12'h7C0,
    parameter logic [11:0] TOHOST_ADDR  = 12'h51E
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [11:0]          s1_csr_addr,
    output logic [DATA_BITS-1:0] s1_csr_rdata,
    output logic                 s1_csr_valid,
    input  logic                 s3_csr_we,
    input  logic [11:0]          s3_csr_addr,
    input  logic [1:0]           s3_csr_op,
    input  logic [DATA_BITS-1:0] s3_csr_wdata,
    input  logic                 s3_csr_src_zero,
    input  logic                 s3_retire,
    output logic [DATA_BITS-1:0] csr_tohost,
    output logic                 csr_illegal
);

    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csrOp_e;

    logic [DATA_BITS-1:0]    tohost_q, tohost_d;
    logic [DATA_BITS-1:0]    scratch_q [NUM_SCRATCH];
    logic [DATA_BITS-1:0]    scratch_d [NUM_SCRATCH];
    logic [COUNTER_BITS-1:0] cycle_q, cycle_d;
    logic [COUNTER_BITS-1:0] instret_q, instret_d;
    logic                    illegal_q, illegal_d;

    logic [DATA_BITS-1:0]    cycleHi, instretHi;
    logic [DATA_BITS-1:0]    s3Old, s3New;
    logic                    s3Writable;
    logic                    writeReq;

    // Upper halves only exist when the counters are twice the data width.
    if (COUNTER_BITS == 2 * DATA_BITS) begin : g_wideCounters
        assign cycleHi   = cycle_q[COUNTER_BITS-1 -: DATA_BITS];
        assign instretHi = instret_q[COUNTER_BITS-1 -: DATA_BITS];
    end else begin : g_narrowCounters
        assign cycleHi   = '0;
        assign instretHi = '0;
    end

    function automatic logic isScratch(input logic [11:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (addr == 12'(SCRATCH_BASE + 12'(i))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic csrWritable(input logic [11:0] addr);
        return (addr == TOHOST_ADDR) || isScratch(addr);
    endfunction

    function automatic logic csrMapped(input logic [11:0] addr);
        return csrWritable(addr) || (addr == ADDR_CYCLE) || (addr == ADDR_INSTRET) ||
               (addr == ADDR_CYCLEH) || (addr == ADDR_INSTRETH);
    endfunction

    function automatic logic [DATA_BITS-1:0] csrRead(input logic [11:0] addr);
        logic [DATA_BITS-1:0] data;
        data = '0;
        if (addr == TOHOST_ADDR)   data = tohost_q;
        if (addr == ADDR_CYCLE)    data = cycle_q[DATA_BITS-1:0];
        if (addr == ADDR_INSTRET)  data = instret_q[DATA_BITS-1:0];
        if (addr == ADDR_CYCLEH)   data = cycleHi;
        if (addr == ADDR_INSTRETH) data = instretHi;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (addr == 12'(SCRATCH_BASE + 12'(i))) data = scratch_q[i];
        end
        return data;
    endfunction

    always_comb begin
        s1_csr_rdata = csrRead(s1_csr_addr);
        s1_csr_valid = csrMapped(s1_csr_addr);
        s3Old        = csrRead(s3_csr_addr);
        s3Writable   = csrWritable(s3_csr_addr);
    end

    // Set/clear with a zero source is a pure read and must not write or trap.
    assign writeReq = s3_csr_we && !stall &&
                      ((s3_csr_op == OP_RW) ||
                       (((s3_csr_op == OP_RS) || (s3_csr_op == OP_RC)) && !s3_csr_src_zero));

    always_comb begin
        case (s3_csr_op)
            OP_RW:   s3New = s3_csr_wdata;
            OP_RS:   s3New = s3Old | s3_csr_wdata;
            OP_RC:   s3New = s3Old & ~s3_csr_wdata;
            default: s3New = s3Old;
        endcase
    end

    always_comb begin
        tohost_d  = tohost_q;
        scratch_d = scratch_q;
        cycle_d   = cycle_q + COUNTER_BITS'(1);
        instret_d = instret_q;
        illegal_d = 1'b0;

        if (s3_retire && !stall) instret_d = instret_q + COUNTER_BITS'(1);

        if (writeReq) begin
            if (!s3Writable) begin
                illegal_d = 1'b1;
            end else begin
                if (s3_csr_addr == TOHOST_ADDR) tohost_d = s3New;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (s3_csr_addr == 12'(SCRATCH_BASE + 12'(i))) scratch_d[i] = s3New;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q  <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            tohost_q  <= tohost_d;
            scratch_q <= scratch_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign csr_tohost  = tohost_q;
    assign csr_illegal = illegal_q;

endmodule
